// File: rtl/game_pkg.sv
// Shared game definitions: state encoding and player-count encoding used by
// the state controller, game logic and graphics.
package game_pkg;

  typedef enum logic [2:0] {
    GS_IDLE      = 3'd0,
    GS_COUNTDOWN = 3'd1,
    GS_PLAY      = 3'd2,
    GS_PAUSED    = 3'd3,
    GS_OVER      = 3'd4
  } game_state_t;

  // Player count is carried as count-1 so four players fit in two bits.
  typedef enum logic [1:0] {
    PLAYERS_1 = 2'd0,
    PLAYERS_2 = 2'd1,
    PLAYERS_3 = 2'd2,
    PLAYERS_4 = 2'd3
  } num_players_t;

  function automatic logic is_timed(input game_state_t s);
    return (s == GS_COUNTDOWN) || (s == GS_PLAY);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled, holds otherwise,
// and flags the wrap cycle as tick.
module tick_divider #(
  parameter int CLK_HZ = 25_000_000
) (
  input  logic clock_in,
  input  logic reset_n_in,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tick = enable && (count_q == MAX_COUNT);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tick ? '0 : count_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) count_q <= '0;
    else             count_q <= count_d;
  end

endmodule

// File: rtl/game_state_controller.sv
// Game sequencer: idle, start countdown, timed round, pause and game over,
// with seconds countdown, one-second tick and play enable.
module game_state_controller
  import game_pkg::*;
#(
  parameter int CLK_HZ        = 25_000_000,
  parameter int ROUND_SECONDS = 180,
  parameter int START_SECONDS = 3
) (
  input  logic       clock_in,
  input  logic       reset_n_in,
  input  logic       start_in,
  input  logic       pause_in,
  input  logic       restart_in,
  input  logic [1:0] num_players_in,
  output logic [2:0] game_state_out,
  output logic [7:0] time_left_out,
  output logic       second_tick_out,
  output logic       play_enable_out,
  output logic [1:0] num_players_out,
  output logic       round_done_out
);

  game_state_t state_q, state_d;
  logic [3:0]  countdown_q, countdown_d;
  logic [7:0]  round_q, round_d;
  logic [7:0]  time_left_q, time_left_d;
  logic [1:0]  players_q, players_d;
  logic        start_q;
  logic        tick_q, tick_d;
  logic        done_q, done_d;
  logic        play_en_q;

  logic start_rise;
  logic run;
  logic clear;
  logic tick;

  assign start_rise = start_in & ~start_q;

  // Kept outside the FSM process so the divider's tick never feeds back into
  // its own enable.
  assign run   = ~restart_in & (state_q == GS_COUNTDOWN ||
                                (state_q == GS_PLAY && !pause_in));
  assign clear = restart_in | (state_q == GS_IDLE && start_rise && !pause_in);

  tick_divider #(
    .CLK_HZ(CLK_HZ)
  ) u_tick_divider (
    .clock_in  (clock_in),
    .reset_n_in(reset_n_in),
    .enable    (run),
    .clear     (clear),
    .tick      (tick)
  );

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    round_d     = round_q;
    players_d   = players_q;
    tick_d      = 1'b0;
    done_d      = 1'b0;

    if (restart_in) begin
      state_d     = GS_IDLE;
      countdown_d = '0;
      round_d     = '0;
    end else begin
      case (state_q)
        GS_IDLE: begin
          if (start_rise && !pause_in) begin
            state_d     = GS_COUNTDOWN;
            countdown_d = 4'(START_SECONDS);
            players_d   = num_players_in;
          end
        end
        GS_COUNTDOWN: begin
          if (tick) begin
            tick_d = 1'b1;
            if (countdown_q <= 4'd1) begin
              state_d     = GS_PLAY;
              countdown_d = '0;
              round_d     = 8'(ROUND_SECONDS);
            end else begin
              countdown_d = countdown_q - 4'd1;
            end
          end
        end
        GS_PLAY: begin
          if (pause_in) begin
            state_d = GS_PAUSED;
          end else if (tick) begin
            tick_d = 1'b1;
            if (round_q <= 8'd1) begin
              state_d = GS_OVER;
              round_d = '0;
              done_d  = 1'b1;
            end else begin
              round_d = round_q - 8'd1;
            end
          end
        end
        GS_PAUSED: begin
          if (!pause_in) state_d = GS_PLAY;
        end
        GS_OVER: begin
          if (start_rise) state_d = GS_IDLE;
        end
        default: begin
          state_d     = GS_IDLE;
          countdown_d = '0;
          round_d     = '0;
        end
      endcase
    end
  end

  // The displayed time is registered from next-state values so it changes on
  // the same edge as the state.
  always_comb begin
    time_left_d = '0;
    if (state_d == GS_COUNTDOWN)                         time_left_d = {4'b0, countdown_d};
    else if (state_d == GS_PLAY || state_d == GS_PAUSED) time_left_d = round_d;
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= GS_IDLE;
      countdown_q <= '0;
      round_q     <= '0;
      time_left_q <= '0;
      players_q   <= '0;
      start_q     <= 1'b0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
      play_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      countdown_q <= countdown_d;
      round_q     <= round_d;
      time_left_q <= time_left_d;
      players_q   <= players_d;
      start_q     <= start_in;
      tick_q      <= tick_d && is_timed(state_q);
      done_q      <= done_d;
      play_en_q   <= (state_d == GS_PLAY);
    end
  end

  assign game_state_out  = state_q;
  assign time_left_out   = time_left_q;
  assign second_tick_out = tick_q;
  assign play_enable_out = play_en_q;
  assign num_players_out = players_q;
  assign round_done_out  = done_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller with CLK_HZ=4, ROUND_SECONDS=3,
// START_SECONDS=2; expected values are hand-derived cycle counts.
module tb_game_state_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, pause, restart;
  logic [1:0] players;
  logic [2:0] state;
  logic [7:0] time_left;
  logic       tick, play_en, done;
  logic [1:0] players_out;

  int total = 0;
  int bad   = 0;

  game_state_controller #(
    .CLK_HZ(4), .ROUND_SECONDS(3), .START_SECONDS(2)
  ) dut (
    .clock_in       (clk),
    .reset_n_in     (rst_n),
    .start_in       (start),
    .pause_in       (pause),
    .restart_in     (restart),
    .num_players_in (players),
    .game_state_out (state),
    .time_left_out  (time_left),
    .second_tick_out(tick),
    .play_enable_out(play_en),
    .num_players_out(players_out),
    .round_done_out (done)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // From IDLE: one start edge, then the full 8-cycle countdown; returns just
  // after the PLAY entry edge with the prescaler at 0.
  task automatic go_to_play(input logic [1:0] p);
    players = p;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(8);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; pause = 0; restart = 0; players = 2'd0;
    #2;
    total++;
    if ({state, time_left, tick, play_en, players_out, done} !== 16'd0) begin
      bad++; $display("FAIL reset_hold outputs=%h want 0", {state, time_left, tick, play_en, players_out, done});
    end
    #1 rst_n = 1'b1;
    step(1);
    total++;
    if ({state, time_left, tick, play_en, players_out, done} !== 16'd0) begin
      bad++; $display("FAIL reset_release outputs=%h want 0", {state, time_left, tick, play_en, players_out, done});
    end
  endtask

  task automatic test_start;
    players = 2'd2;
    start = 1'b1;
    step(1);
    start = 1'b0;
    total++;
    if (state !== 3'd1 || time_left !== 8'd2 || players_out !== 2'd2) begin
      bad++; $display("FAIL start_countdown state=%0d time=%0d players=%0d want 1/2/2", state, time_left, players_out);
    end
    step(4);
    total++;
    if (state !== 3'd1 || time_left !== 8'd1 || tick !== 1'b1) begin
      bad++; $display("FAIL countdown_tick state=%0d time=%0d tick=%0b want 1/1/1", state, time_left, tick);
    end
    step(4);
    total++;
    if (state !== 3'd2 || time_left !== 8'd3 || play_en !== 1'b1) begin
      bad++; $display("FAIL play_entry state=%0d time=%0d play_en=%0b want 2/3/1", state, time_left, play_en);
    end
  endtask

  task automatic test_full_round;
    int ticks = 0;
    int dones = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (tick) ticks++;
      if (done) dones++;
      if (i == 4 || i == 8) begin
        total++;
        if (time_left !== 8'(3 - i / 4)) begin
          bad++; $display("FAIL round_time cycle=%0d time=%0d want %0d", i, time_left, 3 - i / 4);
        end
      end
    end
    total++;
    if (state !== 3'd4 || time_left !== 8'd0 || play_en !== 1'b0 || done !== 1'b1) begin
      bad++; $display("FAIL round_over state=%0d time=%0d play_en=%0b done=%0b want 4/0/0/1", state, time_left, play_en, done);
    end
    total++;
    if (ticks != 3 || dones != 1) begin
      bad++; $display("FAIL round_pulses ticks=%0d dones=%0d want 3/1", ticks, dones);
    end
    step(1);
    total++;
    if (done !== 1'b0 || state !== 3'd4) begin
      bad++; $display("FAIL done_single done=%0b state=%0d want 0/4", done, state);
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    total++;
    if (state !== 3'd0 || time_left !== 8'd0) begin
      bad++; $display("FAIL over_to_idle state=%0d time=%0d want 0/0", state, time_left);
    end
    step(1);
  endtask

  task automatic test_guards;
    pause = 1'b1;
    start = 1'b1;
    step(2);
    total++;
    if (state !== 3'd0 || time_left !== 8'd0) begin
      bad++; $display("FAIL start_while_paused state=%0d time=%0d want 0/0", state, time_left);
    end
    start = 1'b0;
    pause = 1'b0;
    step(1);
    // Start held high through the whole game: no new edge in OVER.
    players = 2'd1;
    start = 1'b1;
    step(1 + 8 + 12);
    total++;
    if (state !== 3'd4) begin
      bad++; $display("FAIL reach_over state=%0d want 4", state);
    end
    step(3);
    total++;
    if (state !== 3'd4) begin
      bad++; $display("FAIL held_start_over state=%0d want 4", state);
    end
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
  endtask

  task automatic test_pause;
    int ticks = 0;
    go_to_play(2'd0);
    step(2);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (tick) ticks++;
    end
    total++;
    if (state !== 3'd3 || time_left !== 8'd3 || play_en !== 1'b0 || ticks != 0) begin
      bad++; $display("FAIL paused state=%0d time=%0d play_en=%0b ticks=%0d want 3/3/0/0", state, time_left, play_en, ticks);
    end
    pause = 1'b0;
    step(1);
    total++;
    if (state !== 3'd2 || play_en !== 1'b1 || tick !== 1'b0) begin
      bad++; $display("FAIL resume state=%0d play_en=%0b tick=%0b want 2/1/0", state, play_en, tick);
    end
    step(1);
    total++;
    if (tick !== 1'b0) begin
      bad++; $display("FAIL resume_early_tick tick=%0b want 0", tick);
    end
    step(1);
    total++;
    if (tick !== 1'b1 || time_left !== 8'd2) begin
      bad++; $display("FAIL resume_tick tick=%0b time=%0d want 1/2", tick, time_left);
    end
    restart = 1'b1;
    step(1);
    restart = 1'b0;
  endtask

  task automatic test_priority;
    go_to_play(2'd3);
    step(11);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    total++;
    if (state !== 3'd0 || done !== 1'b0 || time_left !== 8'd0 || players_out !== 2'd3) begin
      bad++; $display("FAIL restart_final_tick state=%0d done=%0b time=%0d players=%0d want 0/0/0/3", state, done, time_left, players_out);
    end
    step(1);
    total++;
    if (done !== 1'b0 || state !== 3'd0) begin
      bad++; $display("FAIL restart_late_done done=%0b state=%0d want 0/0", done, state);
    end
    go_to_play(2'd1);
    step(3);
    pause = 1'b1;
    step(1);
    total++;
    if (state !== 3'd3 || time_left !== 8'd3 || tick !== 1'b0) begin
      bad++; $display("FAIL pause_on_tick state=%0d time=%0d tick=%0b want 3/3/0", state, time_left, tick);
    end
    pause = 1'b0;
    step(2);
    total++;
    if (tick !== 1'b1 || time_left !== 8'd2) begin
      bad++; $display("FAIL held_tick_after_resume tick=%0b time=%0d want 1/2", tick, time_left);
    end
  endtask

  task automatic test_reset_mid_play;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({state, time_left, tick, play_en, players_out, done} !== 16'd0) begin
      bad++; $display("FAIL async_reset outputs=%h want 0", {state, time_left, tick, play_en, players_out, done});
    end
    #1 rst_n = 1'b1;
    step(1);
    total++;
    if (state !== 3'd0) begin
      bad++; $display("FAIL after_async_reset state=%0d want 0", state);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_full_round();
    test_guards();
    test_pause();
    test_priority();
    test_reset_mid_play();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_state_controller.md
# game_state_controller

Sequences the game state around the shared game logic and display: idle, start countdown, timed round, pause, game over. Turns the debounced start button, pause switch, restart switch and player-count switches into one registered game state. Also produces a seconds countdown, a one-second tick, and a play-enable that gates player movement. Sits in the top level between the debounce/switch inputs and the game logic/graphics.

## Interface
- CLK_HZ, 25_000_000, clock cycles per game second (≥2)
- ROUND_SECONDS, 180, round length in seconds (1..255)
- START_SECONDS, 3, pre-round countdown in seconds (1..15)
- clock_in  input  1  system clock; one clock domain
- reset_n_in  input  1  asynchronous, active-low reset
- start_in  input  1  debounced start/chop button, level; rising edge used
- pause_in  input  1  pause switch, level
- restart_in  input  1  synchronous soft restart, level
- num_players_in  input  2  player count, encoding 0..3 = 1..4 players
- game_state_out  output  3  current state encoding
- time_left_out  output  8  seconds remaining (meaning per state below)
- second_tick_out  output  1  one-cycle pulse per elapsed game second
- play_enable_out  output  1  high only in PLAY
- num_players_out  output  2  player count latched at start
- round_done_out  output  1  one-cycle pulse on PLAY→OVER

## Operation
- States: IDLE=0, COUNTDOWN=1, PLAY=2, PAUSED=3, OVER=4; codes 5–7 recover to IDLE on the next edge.
- Start detection: start_rise = start_in & ~start_q. start_q is registered and reset to 0.
- Prescaler: 0..CLK_HZ-1.
  - Counts only in COUNTDOWN and PLAY.
  - Holds its value in PAUSED, so a partial second resumes.
  - Cleared to 0 on entry to COUNTDOWN and to PLAY.
  - A "tick" is the edge on which prescaler == CLK_HZ-1; the prescaler wraps to 0 on that edge.
- IDLE: on start_rise with pause_in low, go to COUNTDOWN, load START_SECONDS, and latch num_players_in. Start is ignored while pause_in is high.
- COUNTDOWN: each tick decrements the counter. A tick at value 1 enters PLAY and loads ROUND_SECONDS.
- PLAY:
  - pause_in high goes to PAUSED; in the same cycle the tick is suppressed and the prescaler is held.
  - Otherwise each tick decrements time_left.
  - A tick at time_left == 1 sets time_left to 0, enters OVER, and pulses round_done_out.
- PAUSED: pause_in low returns to PLAY without clearing the prescaler. This is the only PAUSED exit apart from restart.
- OVER: start_rise returns to IDLE.
- restart_in high beats every other event in every state:
  - next state is IDLE;
  - time_left and prescaler are cleared;
  - num_players_out is held.
- time_left_out by state: IDLE 0; COUNTDOWN the countdown value; PLAY/PAUSED round seconds remaining; OVER 0.
- Arithmetic: unsigned, 8-bit time, 4-bit countdown. Decrement only on tick and never below 0. Prescaler width is $clog2(CLK_HZ).

## Timing
- All outputs are registered.
- Reset values: game_state_out=0, time_left_out=0, second_tick_out=0, play_enable_out=0, num_players_out=0, round_done_out=0. Prescaler and start_q reset to 0.
- Start latency: start_in rising at edge N is sampled at N; state is COUNTDOWN after edge N+1.
- second_tick_out is high for the cycle after each tick edge, in both COUNTDOWN and PLAY.
- round_done_out coincides with the first cycle of OVER.
- COUNTDOWN lasts exactly START_SECONDS×CLK_HZ cycles.
- PLAY lasts exactly ROUND_SECONDS×CLK_HZ cycles, excluding PAUSED cycles.
- Pause and resume take effect on the next edge.
- Reset asserted mid-round forces all outputs to their reset values immediately, without waiting for a clock edge.

## Structure
- Shared package game_pkg holds:
  - typedef enum logic [2:0] game_state_t with the five encodings;
  - the player-count encoding.
  - Game logic and graphics import it.
- One sub-module, tick_divider (CLK_HZ parameter), with inputs enable, clear, clock_in, reset_n_in and output tick. It implements the prescaler; the FSM and counters live in the top module.

## Test plan
All scenarios use CLK_HZ=4, ROUND_SECONDS=3, START_SECONDS=2.
- Reset: deassert reset_n_in → all outputs 0, state IDLE; assert reset mid-PLAY → outputs 0 with no clock edge.
- Start: one start_rise with num_players_in=2 → COUNTDOWN one edge later, time_left_out=2, num_players_out=2; 4 cycles later time_left_out=1; 8 cycles later PLAY, time_left_out=3.
- Full round: from PLAY entry, 12 cycles → time_left_out 3→2→1→0, three second_tick_out pulses, OVER with a single round_done_out pulse; start_rise → IDLE.
- Pause: pause_in high at prescaler=2 for 10 cycles → time_left_out unchanged, play_enable_out=0, no ticks; release → PLAY next edge, tick 2 cycles after resume.
- Priority: restart_in coinciding with the final tick → IDLE, no round_done_out; pause_in coinciding with a tick → PAUSED, no decrement.
- Guards: start_rise in IDLE with pause_in high → stays IDLE; held start_in (no new edge) in OVER → stays OVER.
